// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-SRAM req/addr_ok/data_ok port, master side is the fetch stage
interface if_fetch_stage_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  modport master (output inst_sram_req, inst_sram_addr, input inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata);
  modport slave  (input inst_sram_req, inst_sram_addr, output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and single-outstanding instruction fetch with delayed-branch redirect.
// Defining IF_ADDR_ERR_EN adds IF_adel and suppresses fetches from misaligned PCs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  IF_stall,
  input  logic                  ID_br_taken,
  input  logic                  ID_br_type,
  input  logic                  ID_j_type,
  input  logic                  ID_jr_type,
  input  logic [15:0]           ID_br_index,
  input  logic [25:0]           ID_j_index,
  input  logic [31:0]           ID_jr_index,
  if_fetch_stage_if.master      sram,
  output logic [31:0]           IF_pc,
  output logic [31:0]           IF_inst,
`ifdef IF_ADDR_ERR_EN
  output logic                  IF_adel,
`endif
  output logic                  IF_busy
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state, next_state;
  logic [31:0] pc, ibuf, next_pc;
  logic valid, accept, addr_err, wait_hit;
`ifdef IF_ADDR_ERR_EN
  assign addr_err = state == S_REQ && pc[1:0] != 2'b00;
`else
  assign addr_err = 1'b0;
`endif
  assign wait_hit = state == S_WAIT && sram.inst_sram_data_ok;
  assign valid = wait_hit || state == S_HOLD;
  assign accept = valid && !IF_stall;
  assign IF_busy = !valid;
  assign IF_pc = pc;
  assign IF_inst = state == S_HOLD ? ibuf : wait_hit ? sram.inst_sram_rdata : NOP_INST;
  assign sram.inst_sram_req = state == S_REQ && !addr_err && !reset;
  assign sram.inst_sram_addr = pc;
  // pc is the delay-slot address here, so branch offsets are relative to it
  always_comb begin
    next_pc = ID_jr_type ? ID_jr_index
            : ID_j_type ? {pc[31:28], ID_j_index, 2'b00}
            : (ID_br_type && ID_br_taken) ? pc + {{14{ID_br_index[15]}}, ID_br_index, 2'b00}
            : pc + 32'd4;
    next_state = state == S_REQ ? (addr_err ? S_HOLD : sram.inst_sram_addr_ok ? S_WAIT : S_REQ)
               : accept ? S_REQ
               : wait_hit ? S_HOLD
               : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_REQ;
      pc <= RESET_PC;
      ibuf <= NOP_INST;
    end else begin
      state <= next_state;
      if (accept) pc <= next_pc;
      if (wait_hit && IF_stall) ibuf <= sram.inst_sram_rdata;
      else if (addr_err) ibuf <= NOP_INST;
    end
  end
`ifdef IF_ADDR_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) IF_adel <= 1'b0;
    else if (addr_err) IF_adel <= 1'b1;
    else if (accept) IF_adel <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: random SRAM latency/stall/redirect stimulus against a PC-sequence reference model
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam int N = 120;
  logic clk = 0, reset = 1, IF_stall = 0;
  logic br_taken = 0, br_type = 0, j_type = 0, jr_type = 0;
  logic [15:0] br_index = 0;
  logic [25:0] j_index = 0;
  logic [31:0] jr_index = 0;
  logic [31:0] IF_pc, IF_inst;
  logic IF_busy;
`ifdef IF_ADDR_ERR_EN
  logic IF_adel;
`endif
  int checks = 0, errors = 0, acc_cnt = 0;
  bit zero_wait = 1, mon_en = 0, pending = 0, last_req_wait = 0;
  logic [31:0] paddr, last_addr;
  int unsigned wcnt;
  logic [31:0] exp_pc[$], exp_inst[$];
  logic p_jr[N], p_j[N], p_br[N], p_tk[N];
  logic [15:0] p_bi[N];
  logic [25:0] p_ji[N];
  logic [31:0] p_jri[N];
  if_fetch_stage_if bus();
  if_fetch_stage dut (
    .clk(clk), .reset(reset), .IF_stall(IF_stall),
    .ID_br_taken(br_taken), .ID_br_type(br_type), .ID_j_type(j_type), .ID_jr_type(jr_type),
    .ID_br_index(br_index), .ID_j_index(j_index), .ID_jr_index(jr_index),
    .sram(bus.master), .IF_pc(IF_pc), .IF_inst(IF_inst),
`ifdef IF_ADDR_ERR_EN
    .IF_adel(IF_adel),
`endif
    .IF_busy(IF_busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // reference program: the PC sequence follows directly from the redirect chosen for each accepted slot
  task automatic build_program();
    logic [31:0] pc, t;
    int kind;
    pc = RESET_PC;
    for (int i = 0; i < N; i++) begin
      exp_pc.push_back(pc);
      exp_inst.push_back(pc[1:0] != 2'b00 ? 32'h0 : mem(pc));
      kind = i < 2 ? 7 : int'($urandom % 8);
      t = $urandom;
`ifdef IF_ADDR_ERR_EN
      if ($urandom % 4 != 0) t[1:0] = 2'b00;
`else
      t[1:0] = 2'b00;
`endif
      p_jri[i] = t;
      p_ji[i] = 26'($urandom);
      p_bi[i] = 16'($urandom);
      p_tk[i] = 1'($urandom);
      p_jr[i] = 0; p_j[i] = 0; p_br[i] = 0;
      if (kind == 0) begin
        p_jr[i] = 1; p_j[i] = 1'($urandom); p_br[i] = 1'($urandom);
        pc = p_jri[i];
      end else if (kind == 1) begin
        p_j[i] = 1; p_br[i] = 1'($urandom);
        pc = (pc & 32'hf000_0000) | (32'(p_ji[i]) * 4);
      end else if (kind == 2) begin
        p_br[i] = 1; p_tk[i] = 1;
        pc = pc + 32'(int'($signed(p_bi[i])) * 4);
      end else if (kind == 3) begin
        p_br[i] = 1; p_tk[i] = 0;
        pc = pc + 4;
      end else begin
        pc = pc + 4;
      end
    end
  endtask
  // stall and redirect driver; junk redirects during stall cycles must be ignored
  initial forever begin
    @(posedge clk); #1;
    IF_stall = acc_cnt >= N ? 1'b1 : zero_wait ? 1'b0 : ($urandom % 4 == 0);
    if (IF_stall) begin
      jr_type = 1'($urandom); j_type = 1'($urandom); br_type = 1'($urandom); br_taken = 1'($urandom);
      br_index = 16'($urandom); j_index = 26'($urandom); jr_index = $urandom;
    end else begin
      jr_type = p_jr[acc_cnt]; j_type = p_j[acc_cnt]; br_type = p_br[acc_cnt]; br_taken = p_tk[acc_cnt];
      br_index = p_bi[acc_cnt]; j_index = p_ji[acc_cnt]; jr_index = p_jri[acc_cnt];
    end
  end
  // SRAM model with random addr_ok and data_ok latency, plus handshake protocol checks
  initial begin
    bus.inst_sram_addr_ok = 0; bus.inst_sram_data_ok = 0; bus.inst_sram_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        pending = 0; last_req_wait = 0;
        bus.inst_sram_addr_ok = 0; bus.inst_sram_data_ok = 0;
      end else begin
        bus.inst_sram_data_ok = pending && wcnt == 0;
        bus.inst_sram_rdata = bus.inst_sram_data_ok ? mem(paddr) : $urandom;
        if (pending && wcnt != 0) wcnt--;
        bus.inst_sram_addr_ok = bus.inst_sram_req && !pending && (zero_wait || $urandom % 3 != 0);
      end
      @(negedge clk);
      if (!reset) begin
        if (bus.inst_sram_req) chk("req_while_outstanding", 32'(pending), 32'd0);
        if (last_req_wait) begin
          chk("req_held", 32'(bus.inst_sram_req), 32'd1);
          chk("addr_stable", bus.inst_sram_addr, last_addr);
        end
        last_req_wait = bus.inst_sram_req && !bus.inst_sram_addr_ok;
        last_addr = bus.inst_sram_addr;
        if (bus.inst_sram_data_ok) pending = 0;
        if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
          pending = 1; paddr = bus.inst_sram_addr;
          wcnt = zero_wait ? 0 : $urandom % 4;
        end
      end
    end
  end
  // monitor: every accepted instruction is compared against the next scoreboard entry
  always @(negedge clk) begin
    if (!reset && mon_en && acc_cnt < N && !IF_busy && !IF_stall) begin
      chk("accept_pc", IF_pc, exp_pc.pop_front());
      chk("accept_inst", IF_inst, exp_inst.pop_front());
`ifdef IF_ADDR_ERR_EN
      chk("accept_adel", 32'(IF_adel), 32'(IF_pc[1:0] != 2'b00));
`endif
      acc_cnt++;
    end
  end
  initial begin
    int cyc;
    build_program();
    #1;
    chk("rst_req", 32'(bus.inst_sram_req), 32'd0);
    @(negedge clk);
    chk("rst_req_held", 32'(bus.inst_sram_req), 32'd0);
    chk("rst_pc", IF_pc, RESET_PC);
    chk("rst_inst", IF_inst, 32'h0);
    chk("rst_busy", 32'(IF_busy), 32'd1);
    #1 reset = 0; mon_en = 1;
    @(negedge clk); #2;
    chk("first_req", 32'(bus.inst_sram_req), 32'd1);
    chk("first_addr", bus.inst_sram_addr, RESET_PC);
    @(negedge clk); #2;
    chk("first_busy", 32'(IF_busy), 32'd0);
    chk("first_inst", IF_inst, mem(RESET_PC));
    @(negedge clk); #2;
    chk("second_req", 32'(bus.inst_sram_req), 32'd1);
    chk("second_addr", bus.inst_sram_addr, RESET_PC + 32'd4);
    zero_wait = 0;
    cyc = 0;
    while (acc_cnt < N && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (acc_cnt < N) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", acc_cnt, N);
    end
    cyc = 0;
    while (!pending && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!pending) begin
      errors++;
      $display("FAIL wait_state_timeout: got no outstanding request expected one");
    end else begin
      @(posedge clk); #2;
      reset = 1;
      #1;
      chk("midrst_req", 32'(bus.inst_sram_req), 32'd0);
      chk("midrst_pc", IF_pc, RESET_PC);
      chk("midrst_busy", 32'(IF_busy), 32'd1);
      chk("midrst_inst", IF_inst, 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
